// File: rtl/mem_stage_if.sv
// Handshake and data buses around the MEM stage: EXE->MEM, MEM->WB, SRAM read data
// and the MEM forward/block bus. "slave" is the MEM stage side, "master" is its environment.
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD   = 78,
  parameter int MS_TO_WS_BUS_WD   = 73,
  parameter int MS_FWD_BLK_BUS_WD = 42
);
  logic                         ws_allowin;
  logic                         ms_allowin;
  logic                         es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus;
  logic                         ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus;
  logic [31:0]                  data_sram_rdata;
  logic [MS_FWD_BLK_BUS_WD-1:0] ms_fwd_blk_bus;

  modport master (
    output ws_allowin,
    output es_to_ms_valid,
    output es_to_ms_bus,
    output data_sram_rdata,
    input  ms_allowin,
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    input  ms_fwd_blk_bus
  );

  modport slave (
    input  ws_allowin,
    input  es_to_ms_valid,
    input  es_to_ms_bus,
    input  data_sram_rdata,
    output ms_allowin,
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    output ms_fwd_blk_bus
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, buffers the one-cycle-valid SRAM read word
// so stalls cannot corrupt it, aligns/extends load data and publishes a forward bus.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  bus_if
);

  typedef struct packed {
    logic        lb;
    logic        lbu;
    logic        lh;
    logic        lhu;
    logic        lw;
    logic        lwl;
    logic        lwr;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] exe_result;
    logic [31:0] pc;
  } es_bus_t;

  logic        ms_valid_q, ms_valid_d;
  es_bus_t     bus_q, bus_d;
  logic        rbuf_valid_q, rbuf_valid_d;
  logic [31:0] rbuf_q, rbuf_d;

  logic        ms_ready_go;
  logic        ms_allowin;
  logic        enter;
  logic        leave;
  logic        first;
  logic [31:0] ld_word;
  logic [1:0]  addr_lo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] final_result;
  logic [3:0]  rf_we;

  // Handshake and read-buffer next state.
  // NOTE: always_comb gives every variable a default before any branch so no latch is inferred.
  always_comb begin
    ms_ready_go  = 1'b1;
    ms_allowin   = !ms_valid_q || (ms_ready_go && bus_if.ws_allowin);
    enter        = bus_if.es_to_ms_valid && ms_allowin;
    leave        = ms_valid_q && bus_if.ws_allowin;
    first        = ms_valid_q && !rbuf_valid_q;

    ms_valid_d   = ms_allowin ? bus_if.es_to_ms_valid : ms_valid_q;
    bus_d        = enter ? es_bus_t'(bus_if.es_to_ms_bus) : bus_q;

    rbuf_valid_d = rbuf_valid_q;
    rbuf_d       = rbuf_q;
    if (leave || enter) begin
      rbuf_valid_d = 1'b0;
    end else if (first) begin
      rbuf_valid_d = 1'b1;
      rbuf_d       = bus_if.data_sram_rdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q   <= 1'b0;
      rbuf_valid_q <= 1'b0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      rbuf_valid_q <= rbuf_valid_d;
    end
  end

  // NOTE: payload registers are qualified by their valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    bus_q  <= bus_d;
    rbuf_q <= rbuf_d;
  end

  // Load data selection and alignment.
  always_comb begin
    ld_word = rbuf_valid_q ? rbuf_q : bus_if.data_sram_rdata;
    addr_lo = bus_q.exe_result[1:0];

    unique case (addr_lo)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

    final_result = bus_q.exe_result;
    rf_we        = 4'b1111;
    if (bus_q.res_from_mem) begin
      final_result = ld_word;
      if (bus_q.lb) begin
        final_result = {{24{ld_byte[7]}}, ld_byte};
      end else if (bus_q.lbu) begin
        final_result = {24'd0, ld_byte};
      end else if (bus_q.lh) begin
        final_result = {{16{ld_half[15]}}, ld_half};
      end else if (bus_q.lhu) begin
        final_result = {16'd0, ld_half};
      end else if (bus_q.lwl) begin
        unique case (addr_lo)
          2'd0:    begin final_result = {ld_word[7:0],  24'd0}; rf_we = 4'b1000; end
          2'd1:    begin final_result = {ld_word[15:0], 16'd0}; rf_we = 4'b1100; end
          2'd2:    begin final_result = {ld_word[23:0],  8'd0}; rf_we = 4'b1110; end
          default: begin final_result = ld_word;                rf_we = 4'b1111; end
        endcase
      end else if (bus_q.lwr) begin
        unique case (addr_lo)
          2'd0:    begin final_result = ld_word;                 rf_we = 4'b1111; end
          2'd1:    begin final_result = {8'd0,  ld_word[31:8]};  rf_we = 4'b0111; end
          2'd2:    begin final_result = {16'd0, ld_word[31:16]}; rf_we = 4'b0011; end
          default: begin final_result = {24'd0, ld_word[31:24]}; rf_we = 4'b0001; end
        endcase
      end
    end

    // An empty slot or a non-writing instruction must never strobe the register file.
    if (!bus_q.gr_we || !ms_valid_q) begin
      rf_we = 4'b0000;
    end
  end

  assign bus_if.ms_allowin     = ms_allowin;
  assign bus_if.ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign bus_if.ms_to_ws_bus   = {rf_we, bus_q.dest, final_result, bus_q.pc};
  // Load data is fully resolved in MEM, so ID never has to block on it.
  assign bus_if.ms_fwd_blk_bus = {{4{ms_valid_q}} & rf_we, bus_q.dest, final_result, 1'b0};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load alignment, stall buffering,
// back-to-back flow and reset behaviour against hand-computed values.
module tb_mem_stage;

  localparam logic [6:0] OP_NONE = 7'b0000000;
  localparam logic [6:0] OP_LB   = 7'b1000000;
  localparam logic [6:0] OP_LBU  = 7'b0100000;
  localparam logic [6:0] OP_LH   = 7'b0010000;
  localparam logic [6:0] OP_LHU  = 7'b0001000;
  localparam logic [6:0] OP_LW   = 7'b0000100;
  localparam logic [6:0] OP_LWL  = 7'b0000010;
  localparam logic [6:0] OP_LWR  = 7'b0000001;

  logic clk;
  logic resetn;
  int   pass_cnt;
  int   total_cnt;

  mem_stage_if ifc ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus_if (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [77:0] mk(input logic [6:0] ops, input logic rfm, input logic gr,
                                     input logic [4:0] dest, input logic [31:0] res,
                                     input logic [31:0] pc);
    return {ops, rfm, gr, dest, res, pc};
  endfunction

  task automatic issue(input logic [77:0] b);
    ifc.es_to_ms_valid = 1'b1;
    ifc.es_to_ms_bus   = b;
    @(posedge clk); #1;
    ifc.es_to_ms_valid = 1'b0;
  endtask

  task automatic drain();
    ifc.ws_allowin     = 1'b1;
    ifc.es_to_ms_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn              = 1'b0;
    ifc.ws_allowin      = 1'b1;
    ifc.es_to_ms_valid  = 1'b0;
    ifc.es_to_ms_bus    = '0;
    ifc.data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (ifc.ms_to_ws_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ifc.ms_to_ws_valid); else pass_cnt++;
    total_cnt++; if (ifc.ms_fwd_blk_bus[41:38] !== 4'b0000) $display("FAIL reset_fwd: got %b expected 0000", ifc.ms_fwd_blk_bus[41:38]); else pass_cnt++;
    total_cnt++; if (ifc.ms_allowin !== 1'b1) $display("FAIL reset_allowin: got %b expected 1", ifc.ms_allowin); else pass_cnt++;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_byte_half();
    issue(mk(OP_LB, 1'b1, 1'b1, 5'd5, 32'h0000_1003, 32'hBFC0_0000));
    ifc.data_sram_rdata = 32'h8011_2233;
    #1;
    total_cnt++; if (ifc.ms_to_ws_valid !== 1'b1) $display("FAIL lb_valid: got %b expected 1", ifc.ms_to_ws_valid); else pass_cnt++;
    total_cnt++; if (ifc.ms_to_ws_bus[63:32] !== 32'hFFFF_FF80) $display("FAIL lb_result: got %h expected ffffff80", ifc.ms_to_ws_bus[63:32]); else pass_cnt++;
    total_cnt++; if (ifc.ms_to_ws_bus[72:64] !== {4'b1111, 5'd5}) $display("FAIL lb_we_dest: got %h expected %h", ifc.ms_to_ws_bus[72:64], {4'b1111, 5'd5}); else pass_cnt++;
    total_cnt++; if (ifc.ms_to_ws_bus[31:0] !== 32'hBFC0_0000) $display("FAIL lb_pc: got %h expected bfc00000", ifc.ms_to_ws_bus[31:0]); else pass_cnt++;
    total_cnt++; if (ifc.ms_fwd_blk_bus !== {4'b1111, 5'd5, 32'hFFFF_FF80, 1'b0}) $display("FAIL lb_fwd: got %h expected %h", ifc.ms_fwd_blk_bus, {4'b1111, 5'd5, 32'hFFFF_FF80, 1'b0}); else pass_cnt++;
    drain();

    issue(mk(OP_LHU, 1'b1, 1'b1, 5'd6, 32'h0000_2002, 32'hBFC0_0004));
    ifc.data_sram_rdata = 32'h8001_1234;
    #1;
    total_cnt++; if (ifc.ms_to_ws_bus[63:32] !== 32'h0000_8001) $display("FAIL lhu_result: got %h expected 00008001", ifc.ms_to_ws_bus[63:32]); else pass_cnt++;
    drain();

    issue(mk(OP_LH, 1'b1, 1'b1, 5'd6, 32'h0000_2000, 32'hBFC0_0008));
    ifc.data_sram_rdata = 32'h0000_8001;
    #1;
    total_cnt++; if (ifc.ms_to_ws_bus[63:32] !== 32'hFFFF_8001) $display("FAIL lh_result: got %h expected ffff8001", ifc.ms_to_ws_bus[63:32]); else pass_cnt++;
    drain();

    issue(mk(OP_LBU, 1'b1, 1'b1, 5'd8, 32'h0000_2001, 32'hBFC0_000C));
    ifc.data_sram_rdata = 32'h0000_9A00;
    #1;
    total_cnt++; if (ifc.ms_to_ws_bus[63:32] !== 32'h0000_009A) $display("FAIL lbu_result: got %h expected 0000009a", ifc.ms_to_ws_bus[63:32]); else pass_cnt++;
    drain();
  endtask

  task automatic test_unaligned_word();
    issue(mk(OP_LWL, 1'b1, 1'b1, 5'd9, 32'h0000_3001, 32'hBFC0_0010));
    ifc.data_sram_rdata = 32'hAABB_CCDD;
    #1;
    total_cnt++; if (ifc.ms_to_ws_bus[63:32] !== 32'hCCDD_0000) $display("FAIL lwl_result: got %h expected ccdd0000", ifc.ms_to_ws_bus[63:32]); else pass_cnt++;
    total_cnt++; if (ifc.ms_to_ws_bus[72:69] !== 4'b1100) $display("FAIL lwl_we: got %b expected 1100", ifc.ms_to_ws_bus[72:69]); else pass_cnt++;
    drain();

    issue(mk(OP_LWR, 1'b1, 1'b1, 5'd9, 32'h0000_3002, 32'hBFC0_0014));
    ifc.data_sram_rdata = 32'hAABB_CCDD;
    #1;
    total_cnt++; if (ifc.ms_to_ws_bus[63:32] !== 32'h0000_AABB) $display("FAIL lwr_result: got %h expected 0000aabb", ifc.ms_to_ws_bus[63:32]); else pass_cnt++;
    total_cnt++; if (ifc.ms_fwd_blk_bus[41:38] !== 4'b0011) $display("FAIL lwr_fwd_we: got %b expected 0011", ifc.ms_fwd_blk_bus[41:38]); else pass_cnt++;
    drain();
  endtask

  task automatic test_non_load();
    issue(mk(OP_NONE, 1'b0, 1'b1, 5'd10, 32'h1234_5678, 32'hBFC0_0018));
    ifc.data_sram_rdata = 32'hFFFF_FFFF;
    #1;
    total_cnt++; if (ifc.ms_to_ws_bus[72:32] !== {4'b1111, 5'd10, 32'h1234_5678}) $display("FAIL alu_pass: got %h expected %h", ifc.ms_to_ws_bus[72:32], {4'b1111, 5'd10, 32'h1234_5678}); else pass_cnt++;
    drain();

    issue(mk(OP_LW, 1'b1, 1'b0, 5'd11, 32'h0000_4000, 32'hBFC0_001C));
    ifc.data_sram_rdata = 32'h5555_AAAA;
    #1;
    total_cnt++; if (ifc.ms_to_ws_bus[72:69] !== 4'b0000) $display("FAIL nowe_we: got %b expected 0000", ifc.ms_to_ws_bus[72:69]); else pass_cnt++;
    total_cnt++; if (ifc.ms_fwd_blk_bus[41:38] !== 4'b0000) $display("FAIL nowe_fwd: got %b expected 0000", ifc.ms_fwd_blk_bus[41:38]); else pass_cnt++;
    drain();
    total_cnt++; if (ifc.ms_fwd_blk_bus[41:38] !== 4'b0000 || ifc.ms_to_ws_valid !== 1'b0) $display("FAIL empty_slot: got fwd=%b valid=%b expected 0000/0", ifc.ms_fwd_blk_bus[41:38], ifc.ms_to_ws_valid); else pass_cnt++;
  endtask

  task automatic test_stall();
    ifc.ws_allowin = 1'b0;
    issue(mk(OP_LW, 1'b1, 1'b1, 5'd7, 32'h0000_0100, 32'hBFC0_0020));
    ifc.data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    total_cnt++; if (ifc.ms_allowin !== 1'b0) $display("FAIL stall_allowin: got %b expected 0", ifc.ms_allowin); else pass_cnt++;
    total_cnt++; if (ifc.ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) $display("FAIL stall_c1: got %h expected deadbeef", ifc.ms_to_ws_bus[63:32]); else pass_cnt++;
    @(posedge clk); #1;
    ifc.data_sram_rdata = 32'h0BAD_F00D;
    ifc.es_to_ms_valid  = 1'b1;
    ifc.es_to_ms_bus    = mk(OP_LW, 1'b1, 1'b1, 5'd9, 32'h0000_0200, 32'hBFC0_0024);
    #1;
    total_cnt++; if (ifc.ms_to_ws_bus[68:32] !== {5'd7, 32'hDEAD_BEEF}) $display("FAIL stall_c2: got %h expected %h", ifc.ms_to_ws_bus[68:32], {5'd7, 32'hDEAD_BEEF}); else pass_cnt++;
    @(posedge clk); #1;
    ifc.data_sram_rdata = 32'h1234_5678;
    #1;
    total_cnt++; if (ifc.ms_to_ws_bus[68:32] !== {5'd7, 32'hDEAD_BEEF} || ifc.ms_to_ws_valid !== 1'b1) $display("FAIL stall_c3: got %h expected %h", ifc.ms_to_ws_bus[68:32], {5'd7, 32'hDEAD_BEEF}); else pass_cnt++;
    ifc.ws_allowin      = 1'b1;
    ifc.data_sram_rdata = 32'h5555_5555;
    #1;
    total_cnt++; if (ifc.ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF || ifc.ms_allowin !== 1'b1) $display("FAIL stall_release: got %h allowin=%b expected deadbeef/1", ifc.ms_to_ws_bus[63:32], ifc.ms_allowin); else pass_cnt++;
    // Stalled instruction leaves while the waiting one enters on the same edge.
    @(posedge clk); #1;
    ifc.es_to_ms_valid  = 1'b0;
    ifc.data_sram_rdata = 32'hCAFE_F00D;
    #1;
    total_cnt++; if (ifc.ms_to_ws_bus[68:32] !== {5'd9, 32'hCAFE_F00D} || ifc.ms_to_ws_valid !== 1'b1) $display("FAIL swap_entry: got %h expected %h", ifc.ms_to_ws_bus[68:32], {5'd9, 32'hCAFE_F00D}); else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [77:0] loads [3];
    logic [31:0] words [3];
    logic [31:0] exp   [3];
    loads[0] = mk(OP_LW,  1'b1, 1'b1, 5'd12, 32'h0000_5000, 32'hBFC0_0030);
    loads[1] = mk(OP_LBU, 1'b1, 1'b1, 5'd13, 32'h0000_5006, 32'hBFC0_0034);
    loads[2] = mk(OP_LW,  1'b1, 1'b1, 5'd14, 32'h0000_5008, 32'hBFC0_0038);
    words[0] = 32'h1111_1111;  exp[0] = 32'h1111_1111;
    words[1] = 32'h00AB_0000;  exp[1] = 32'h0000_00AB;
    words[2] = 32'h3333_3333;  exp[2] = 32'h3333_3333;
    ifc.ws_allowin = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      ifc.es_to_ms_valid = (k < 3);
      if (k < 3) ifc.es_to_ms_bus = loads[k];
      if (k > 0) begin
        ifc.data_sram_rdata = words[k-1];
        #1;
        total_cnt++; if (ifc.ms_to_ws_valid !== 1'b1 || ifc.ms_allowin !== 1'b1 || ifc.ms_to_ws_bus[68:32] !== {loads[k-1][68:64], exp[k-1]})
          $display("FAIL b2b_%0d: got valid=%b allowin=%b %h expected 1/1 %h", k-1, ifc.ms_to_ws_valid, ifc.ms_allowin, ifc.ms_to_ws_bus[68:32], {loads[k-1][68:64], exp[k-1]});
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
    ifc.es_to_ms_valid = 1'b0;
    total_cnt++; if (ifc.ms_to_ws_valid !== 1'b0) $display("FAIL b2b_empty: got %b expected 0", ifc.ms_to_ws_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    ifc.ws_allowin = 1'b0;
    issue(mk(OP_LW, 1'b1, 1'b1, 5'd3, 32'h0000_6000, 32'hBFC0_0040));
    ifc.data_sram_rdata = 32'h1122_3344;
    @(posedge clk); #1;
    ifc.data_sram_rdata = 32'h0000_0000;
    resetn = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (ifc.ms_to_ws_valid !== 1'b0) $display("FAIL rst_stall_valid: got %b expected 0", ifc.ms_to_ws_valid); else pass_cnt++;
    total_cnt++; if (ifc.ms_fwd_blk_bus[41:38] !== 4'b0000) $display("FAIL rst_stall_fwd: got %b expected 0000", ifc.ms_fwd_blk_bus[41:38]); else pass_cnt++;
    total_cnt++; if (ifc.ms_allowin !== 1'b1) $display("FAIL rst_stall_allowin: got %b expected 1", ifc.ms_allowin); else pass_cnt++;
    resetn         = 1'b1;
    ifc.ws_allowin = 1'b1;
    issue(mk(OP_LW, 1'b1, 1'b1, 5'd4, 32'h0000_6004, 32'hBFC0_0044));
    ifc.data_sram_rdata = 32'h6677_8899;
    #1;
    total_cnt++; if (ifc.ms_to_ws_bus[68:32] !== {5'd4, 32'h6677_8899}) $display("FAIL rst_stall_fresh: got %h expected %h", ifc.ms_to_ws_bus[68:32], {5'd4, 32'h6677_8899}); else pass_cnt++;
    drain();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_byte_half();
    test_unaligned_word();
    test_non_load();
    test_stall();
    test_back_to_back();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
